// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite widths, response codes and arbiter state encoding.
package axi_lite_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR} arb_state_t;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after i_ptr wins.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);
    // Scan farthest-first so the nearest requester is the last (winning) assignment.
    always_comb begin
        o_grant = '0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (i_req[(int'(i_ptr) + k) % N]) o_idx = IW'((int'(i_ptr) + k) % N);
        o_grant[o_idx] = |i_req;
    end
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin N-to-1 AXI4-Lite arbiter, one read or write in flight.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    localparam int N = NUM_MASTERS,
    localparam int IW = $clog2(NUM_MASTERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 i_m_arvalid,
    output logic [N-1:0]                 o_m_arready,
    input  logic [N-1:0][AXI_ADDR_W-1:0] i_m_araddr,
    output logic [N-1:0]                 o_m_rvalid,
    input  logic [N-1:0]                 i_m_rready,
    output logic [N-1:0][AXI_DATA_W-1:0] o_m_rdata,
    output logic [N-1:0][1:0]            o_m_rresp,
    input  logic [N-1:0]                 i_m_awvalid,
    output logic [N-1:0]                 o_m_awready,
    input  logic [N-1:0][AXI_ADDR_W-1:0] i_m_awaddr,
    input  logic [N-1:0]                 i_m_wvalid,
    output logic [N-1:0]                 o_m_wready,
    input  logic [N-1:0][AXI_DATA_W-1:0] i_m_wdata,
    input  logic [N-1:0][3:0]            i_m_wmask,
    output logic [N-1:0]                 o_m_bvalid,
    input  logic [N-1:0]                 i_m_bready,
    output logic [N-1:0][1:0]            o_m_bresp,
    output logic                         o_s_arvalid,
    input  logic                         i_s_arready,
    output logic [AXI_ADDR_W-1:0]        o_s_araddr,
    input  logic                         i_s_rvalid,
    output logic                         o_s_rready,
    input  logic [AXI_DATA_W-1:0]        i_s_rdata,
    input  logic [1:0]                   i_s_rresp,
    output logic                         o_s_awvalid,
    input  logic                         i_s_awready,
    output logic [AXI_ADDR_W-1:0]        o_s_awaddr,
    output logic                         o_s_wvalid,
    input  logic                         i_s_wready,
    output logic [AXI_DATA_W-1:0]        o_s_wdata,
    output logic [3:0]                   o_s_wmask,
    input  logic                         i_s_bvalid,
    output logic                         o_s_bready,
    input  logic [1:0]                   i_s_bresp
);
    arb_state_t r_state, w_next;
    logic [IW-1:0] r_owner, r_ptr, w_idx;
    logic [N-1:0] w_req, w_grant;
    logic r_ar_done, r_aw_done, r_w_done, w_done;

    assign w_req = i_m_arvalid | i_m_awvalid;
    assign o_m_rdata = {N{i_s_rdata}};
    assign o_m_rresp = {N{i_s_rresp}};
    assign o_m_bresp = {N{i_s_bresp}};

    rr_arbiter #(.N(N)) u_rr (
        .i_req(w_req),
        .i_ptr(r_ptr),
        .o_grant(w_grant),
        .o_idx(w_idx)
    );

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        o_s_arvalid = 1'b0;
        o_s_araddr = '0;
        o_s_rready = 1'b0;
        o_s_awvalid = 1'b0;
        o_s_awaddr = '0;
        o_s_wvalid = 1'b0;
        o_s_wdata = '0;
        o_s_wmask = '0;
        o_s_bready = 1'b0;
        o_m_arready = '0;
        o_m_rvalid = '0;
        o_m_awready = '0;
        o_m_wready = '0;
        o_m_bvalid = '0;
        case (r_state)
            IDLE: w_next = |w_grant ? (i_m_awvalid[w_idx] ? WR : RD) : IDLE;
            RD: begin
                o_s_arvalid = i_m_arvalid[r_owner] & ~r_ar_done;
                o_s_araddr = i_m_araddr[r_owner];
                o_m_arready[r_owner] = i_s_arready & ~r_ar_done;
                o_s_rready = i_m_rready[r_owner];
                o_m_rvalid[r_owner] = i_s_rvalid;
                w_done = i_s_rvalid & i_m_rready[r_owner];
                w_next = w_done ? IDLE : RD;
            end
            WR: begin
                o_s_awvalid = i_m_awvalid[r_owner] & ~r_aw_done;
                o_s_awaddr = i_m_awaddr[r_owner];
                o_m_awready[r_owner] = i_s_awready & ~r_aw_done;
                o_s_wvalid = i_m_wvalid[r_owner] & ~r_w_done;
                o_s_wdata = i_m_wdata[r_owner];
                o_s_wmask = i_m_wmask[r_owner];
                o_m_wready[r_owner] = i_s_wready & ~r_w_done;
                o_s_bready = i_m_bready[r_owner];
                o_m_bvalid[r_owner] = i_s_bvalid;
                w_done = i_s_bvalid & i_m_bready[r_owner];
                w_next = w_done ? IDLE : WR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr <= '0;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |w_grant) r_owner <= w_idx;
            if (w_done) begin
                r_ptr <= (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
                r_ar_done <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done <= 1'b0;
            end else begin
                r_ar_done <= r_ar_done | (o_s_arvalid & i_s_arready);
                r_aw_done <= r_aw_done | (o_s_awvalid & i_s_awready);
                r_w_done <= r_w_done | (o_s_wvalid & i_s_wready);
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed self-checking bench for the two-master AXI4-Lite arbiter.
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] m_arvalid = '0, m_arready, m_rvalid, m_rready = '0;
    logic [1:0] m_awvalid = '0, m_awready, m_wvalid = '0, m_wready, m_bvalid, m_bready = '0;
    logic [1:0][31:0] m_araddr = '0, m_awaddr = '0, m_wdata = '0, m_rdata;
    logic [1:0][3:0] m_wmask = '0;
    logic [1:0][1:0] m_rresp, m_bresp;
    logic s_arvalid, s_arready = 1'b0, s_rvalid = 1'b0, s_rready;
    logic s_awvalid, s_awready = 1'b0, s_wvalid, s_wready = 1'b0, s_bvalid = 1'b0, s_bready;
    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata = '0;
    logic [3:0] s_wmask;
    logic [1:0] s_rresp = '0, s_bresp = '0;

    int n_err = 0, n_chk = 0, n_ar = 0, n_aw = 0, n_w = 0;
    int ar0, aw0, w0;

    axi_lite_arbiter #(.NUM_MASTERS(2)) dut (
        .clk(clk), .reset(reset),
        .i_m_arvalid(m_arvalid), .o_m_arready(m_arready), .i_m_araddr(m_araddr),
        .o_m_rvalid(m_rvalid), .i_m_rready(m_rready), .o_m_rdata(m_rdata), .o_m_rresp(m_rresp),
        .i_m_awvalid(m_awvalid), .o_m_awready(m_awready), .i_m_awaddr(m_awaddr),
        .i_m_wvalid(m_wvalid), .o_m_wready(m_wready), .i_m_wdata(m_wdata), .i_m_wmask(m_wmask),
        .o_m_bvalid(m_bvalid), .i_m_bready(m_bready), .o_m_bresp(m_bresp),
        .o_s_arvalid(s_arvalid), .i_s_arready(s_arready), .o_s_araddr(s_araddr),
        .i_s_rvalid(s_rvalid), .o_s_rready(s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
        .o_s_awvalid(s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(s_awaddr),
        .o_s_wvalid(s_wvalid), .i_s_wready(s_wready), .o_s_wdata(s_wdata), .o_s_wmask(s_wmask),
        .i_s_bvalid(s_bvalid), .o_s_bready(s_bready), .i_s_bresp(s_bresp)
    );

    always @(posedge clk) begin
        if (!reset) begin
            if (s_arvalid && s_arready) n_ar <= n_ar + 1;
            if (s_awvalid && s_awready) n_aw <= n_aw + 1;
            if (s_wvalid && s_wready) n_w <= n_w + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_ptr", 32'(dut.r_ptr), 0);
        chk("rst_s_arvalid", 32'(s_arvalid), 0);
        chk("rst_m_arready", 32'(m_arready), 0);

        // single read from master 0
        m_arvalid = 2'b01; m_araddr[0] = 32'h8000_0000; m_rready = 2'b11; s_arready = 1'b1;
        #1;
        chk("rd_idle_s_arvalid", 32'(s_arvalid), 0);
        tick;
        chk("rd_s_arvalid", 32'(s_arvalid), 1);
        chk("rd_s_araddr", s_araddr, 32'h8000_0000);
        chk("rd_m_arready", 32'(m_arready), 32'h1);
        tick;
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = AXI_RESP_OKAY;
        #1;
        chk("rd_m_rvalid", 32'(m_rvalid), 32'h1);
        chk("rd_m0_rdata", m_rdata[0], 32'h1234_5678);
        chk("rd_ar_done", 32'(s_arvalid), 0);
        chk("rd_s_rready", 32'(s_rready), 1);
        tick;
        s_rvalid = 1'b0;
        #1;
        chk("rd_end_state", 32'(dut.r_state), 32'(IDLE));
        chk("rd_end_ptr", 32'(dut.r_ptr), 1);
        chk("rd_end_rvalid", 32'(m_rvalid), 0);

        // simultaneous read (m0) and write (m1) after reset
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("sim_rst_ptr", 32'(dut.r_ptr), 0);
        m_arvalid = 2'b01; m_araddr[0] = 32'h100;
        m_awvalid = 2'b10; m_awaddr[1] = 32'h200; m_wvalid = 2'b10;
        m_wdata[1] = 32'hDEAD_BEEF; m_wmask[1] = 4'hF; m_bready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        tick;
        chk("sim_state_rd", 32'(dut.r_state), 32'(RD));
        chk("sim_s_arvalid", 32'(s_arvalid), 1);
        chk("sim_s_awvalid_hold", 32'(s_awvalid), 0);
        chk("sim_s_wvalid_hold", 32'(s_wvalid), 0);
        chk("sim_m_awready_hold", 32'(m_awready), 0);
        tick;
        m_arvalid = 2'b00; s_rvalid = 1'b1;
        #1;
        chk("sim_m_rvalid", 32'(m_rvalid), 32'h1);
        chk("sim_s_awvalid_r", 32'(s_awvalid), 0);
        tick;
        s_rvalid = 1'b0;
        #1;
        chk("sim_mid_state", 32'(dut.r_state), 32'(IDLE));
        chk("sim_mid_ptr", 32'(dut.r_ptr), 1);
        tick;
        chk("sim_state_wr", 32'(dut.r_state), 32'(WR));
        chk("sim_s_awvalid", 32'(s_awvalid), 1);
        chk("sim_s_awaddr", s_awaddr, 32'h200);
        chk("sim_s_wvalid", 32'(s_wvalid), 1);
        chk("sim_s_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("sim_s_wmask", 32'(s_wmask), 32'hF);
        chk("sim_m_awready", 32'(m_awready), 32'h2);
        chk("sim_m_wready", 32'(m_wready), 32'h2);
        tick;
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1;
        #1;
        chk("sim_m_bvalid", 32'(m_bvalid), 32'h2);
        chk("sim_aw_done", 32'(s_awvalid), 0);
        chk("sim_w_done", 32'(s_wvalid), 0);
        chk("sim_s_bready", 32'(s_bready), 1);
        tick;
        s_bvalid = 1'b0;
        #1;
        chk("sim_end_state", 32'(dut.r_state), 32'(IDLE));
        chk("sim_end_ptr", 32'(dut.r_ptr), 0);

        // fairness: both masters read continuously
        m_arvalid = 2'b11; m_araddr[0] = 32'hA0; m_araddr[1] = 32'hB0;
        #1;
        for (int k = 0; k < 20; k++) begin
            tick;
            chk("fair_arready", 32'(m_arready), (k % 2) ? 32'h2 : 32'h1);
            chk("fair_araddr", s_araddr, (k % 2) ? 32'hB0 : 32'hA0);
            tick;
            s_rvalid = 1'b1;
            #1;
            chk("fair_rvalid", 32'(m_rvalid), (k % 2) ? 32'h2 : 32'h1);
            tick;
            s_rvalid = 1'b0;
            if (k == 19) m_arvalid = 2'b00;
            #1;
        end
        chk("fair_end_ptr", 32'(dut.r_ptr), 0);

        // W presented two cycles before AW, then AW accepted a cycle after W
        m_wvalid = 2'b01; m_wdata[0] = 32'hCAFE_F00D; m_wmask[0] = 4'h3;
        s_awready = 1'b0; s_wready = 1'b1;
        #1;
        chk("wfirst_idle_wready", 32'(m_wready), 0);
        tick;
        tick;
        chk("wfirst_still_idle", 32'(dut.r_state), 32'(IDLE));
        chk("wfirst_s_wvalid_idle", 32'(s_wvalid), 0);
        m_awvalid = 2'b01; m_awaddr[0] = 32'h300;
        aw0 = n_aw; w0 = n_w;
        #1;
        tick;
        chk("wfirst_s_awvalid", 32'(s_awvalid), 1);
        chk("wfirst_s_wvalid", 32'(s_wvalid), 1);
        chk("wfirst_m_awready", 32'(m_awready), 0);
        chk("wfirst_m_wready", 32'(m_wready), 32'h1);
        tick;
        m_wvalid = 2'b00; s_awready = 1'b1;
        #1;
        chk("wfirst_w_done", 32'(s_wvalid), 0);
        chk("wfirst_m_awready2", 32'(m_awready), 32'h1);
        tick;
        m_awvalid = 2'b00; s_bvalid = 1'b1;
        #1;
        chk("wfirst_m_bvalid", 32'(m_bvalid), 32'h1);
        chk("wfirst_aw_done", 32'(s_awvalid), 0);
        tick;
        s_bvalid = 1'b0;
        #1;
        chk("wfirst_end_state", 32'(dut.r_state), 32'(IDLE));
        chk("wfirst_aw_count", 32'(n_aw - aw0), 1);
        chk("wfirst_w_count", 32'(n_w - w0), 1);
        chk("wfirst_ptr", 32'(dut.r_ptr), 1);

        // backpressure on AR then on R, master 1 owns
        m_arvalid = 2'b10; m_araddr[1] = 32'h400; m_rready = 2'b00; s_arready = 1'b0;
        ar0 = n_ar;
        #1;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_s_arvalid", 32'(s_arvalid), 1);
            chk("bp_s_araddr", s_araddr, 32'h400);
            tick;
        end
        s_arready = 1'b1;
        #1;
        chk("bp_m_arready", 32'(m_arready), 32'h2);
        tick;
        m_arvalid = 2'b00; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55AA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_m_rvalid", 32'(m_rvalid), 32'h2);
            chk("bp_s_rready", 32'(s_rready), 0);
            chk("bp_state", 32'(dut.r_state), 32'(RD));
            tick;
        end
        m_rready = 2'b10;
        #1;
        chk("bp_s_rready_on", 32'(s_rready), 1);
        tick;
        s_rvalid = 1'b0; m_rready = 2'b11;
        #1;
        chk("bp_end_state", 32'(dut.r_state), 32'(IDLE));
        chk("bp_ar_count", 32'(n_ar - ar0), 1);
        chk("bp_ptr", 32'(dut.r_ptr), 0);

        // R arriving in the same cycle as the AR handshake
        m_arvalid = 2'b01; s_arready = 1'b1; ar0 = n_ar;
        #1;
        tick;
        s_rvalid = 1'b1;
        #1;
        chk("same_m_arready", 32'(m_arready), 32'h1);
        chk("same_m_rvalid", 32'(m_rvalid), 32'h1);
        tick;
        m_arvalid = 2'b00; s_rvalid = 1'b0;
        #1;
        chk("same_end_state", 32'(dut.r_state), 32'(IDLE));
        chk("same_ar_count", 32'(n_ar - ar0), 1);

        // reset mid-write after AW handshake, then a normal read
        m_awvalid = 2'b10; m_awaddr[1] = 32'h600; m_wvalid = 2'b10; s_awready = 1'b1; s_wready = 1'b0;
        #1;
        tick;
        chk("rstwr_s_awvalid", 32'(s_awvalid), 1);
        tick;
        m_awvalid = 2'b00;
        #1;
        chk("rstwr_aw_done", 32'(s_awvalid), 0);
        chk("rstwr_s_wvalid", 32'(s_wvalid), 1);
        reset = 1'b1;
        tick;
        reset = 1'b0; m_wvalid = 2'b00;
        #1;
        chk("rstwr_state", 32'(dut.r_state), 32'(IDLE));
        chk("rstwr_ptr", 32'(dut.r_ptr), 0);
        chk("rstwr_outs", {26'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, |m_wready}, 0);
        chk("rstwr_flag", 32'(dut.r_aw_done), 0);
        m_arvalid = 2'b10; m_araddr[1] = 32'h500; s_arready = 1'b1;
        #1;
        tick;
        chk("rstwr_rd_arvalid", 32'(s_arvalid), 1);
        chk("rstwr_rd_araddr", s_araddr, 32'h500);
        tick;
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h77;
        #1;
        chk("rstwr_rd_rvalid", 32'(m_rvalid), 32'h2);
        chk("rstwr_rd_rdata", m_rdata[1], 32'h77);
        tick;
        s_rvalid = 1'b0;
        #1;
        chk("rstwr_rd_end", 32'(dut.r_state), 32'(IDLE));
        chk("rstwr_rd_ptr", 32'(dut.r_ptr), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
